// File: rtl/alu_pkg.sv
// Shared definitions for the ALU datapath and its controller.
package alu_pkg;

   // Opcode field width (instr[7:4]); fixed for every instance.
   localparam int unsigned OPW = 4;

   localparam logic [OPW-1:0] OP_NOP  = 4'd0;
   localparam logic [OPW-1:0] OP_ADD  = 4'd4;
   localparam logic [OPW-1:0] OP_SUB  = 4'd5;
   localparam logic [OPW-1:0] OP_NAND = 4'd8;
   localparam logic [OPW-1:0] OP_SHL  = 4'd9;
   localparam logic [OPW-1:0] OP_SHR  = 4'd10;

   typedef enum logic [2:0] {
      AM_NONE = 3'b000,
      AM_ADD  = 3'b001,
      AM_SUB  = 3'b010,
      AM_NAND = 3'b011,
      AM_SHL  = 3'b100,
      AM_SHR  = 3'b101
   } alu_mode_e;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_DECODE = 2'd1,
      S_EXEC   = 2'd2,
      S_WB     = 2'd3
   } state_e;

endpackage

// File: rtl/alu_ctrl_if.sv
// Instruction handshake, register-file and ALU control bundle.
interface alu_ctrl_if;

   logic [7:0] instr;
   logic       instr_valid;
   logic       instr_ready;
   logic [1:0] rf_ra;
   logic [1:0] rf_rb;
   logic [1:0] rf_wa;
   logic       rf_we;
   logic [2:0] alu_mode;
   logic       alu_z;
   logic       alu_n;
   logic       z_flag;
   logic       n_flag;
   logic       illegal;

   // Controller side
   modport slave (
      input  instr, instr_valid, alu_z, alu_n,
      output instr_ready, rf_ra, rf_rb, rf_wa, rf_we, alu_mode,
             z_flag, n_flag, illegal
   );

   // Instruction source / ALU side
   modport master (
      output instr, instr_valid, alu_z, alu_n,
      input  instr_ready, rf_ra, rf_rb, rf_wa, rf_we, alu_mode,
             z_flag, n_flag, illegal
   );

endinterface

// File: rtl/alu_decode.sv
// Opcode decoder: ALU mode select, legality and write-back requirement.
module alu_decode
   import alu_pkg::*;
(
   input  logic [OPW-1:0] opcode_i,
   output alu_mode_e      alu_mode_o,
   output logic           legal_o,
   output logic           writes_rf_o
);

   // Map each opcode to its ALU mode; undefined opcodes are illegal and never write.
   always_comb begin
      alu_mode_o  = AM_NONE;
      legal_o     = 1'b1;
      writes_rf_o = 1'b1;
      case (opcode_i)
         OP_NOP:  writes_rf_o = 1'b0;
         OP_ADD:  alu_mode_o  = AM_ADD;
         OP_SUB:  alu_mode_o  = AM_SUB;
         OP_NAND: alu_mode_o  = AM_NAND;
         OP_SHL:  alu_mode_o  = AM_SHL;
         OP_SHR:  alu_mode_o  = AM_SHR;
         default: begin
            legal_o     = 1'b0;
            writes_rf_o = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/alu_ctrl.sv
// Multi-cycle ALU controller: IDLE -> DECODE -> EXEC -> WB.
module alu_ctrl
   import alu_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   alu_ctrl_if.slave  bus
);

   state_e     state_q;
   logic [7:0] ir_q;
   logic       z_q;
   logic       n_q;

   alu_mode_e  dec_mode;
   logic       dec_legal;
   logic       dec_wr;
   logic       hs;

   // Decoding the latched IR keeps every control output a function of registers only.
   alu_decode u_dec (
      .opcode_i    (ir_q[7:4]),
      .alu_mode_o  (dec_mode),
      .legal_o     (dec_legal),
      .writes_rf_o (dec_wr)
   );

   assign hs = bus.instr_valid && (state_q == S_IDLE);

   // Sequencer: latch IR on handshake, capture flags at end of EXEC; reset aborts any op.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         ir_q    <= '0;
         z_q     <= 1'b0;
         n_q     <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (hs) begin
                  ir_q    <= bus.instr;
                  state_q <= S_DECODE;
               end
            end
            S_DECODE: state_q <= dec_wr ? S_EXEC : S_IDLE;
            S_EXEC: begin
               z_q     <= bus.alu_z;
               n_q     <= bus.alu_n;
               state_q <= S_WB;
            end
            S_WB:    state_q <= S_IDLE;
            default: state_q <= S_IDLE;
         endcase
      end
   end

   // Write strobe and illegal pulse are state-decoded, so a reset edge cancels them at once.
   assign bus.instr_ready = (state_q == S_IDLE);
   assign bus.rf_ra       = ir_q[3:2];
   assign bus.rf_rb       = ir_q[1:0];
   assign bus.rf_wa       = ir_q[3:2];
   assign bus.rf_we       = (state_q == S_WB);
   assign bus.alu_mode    = (state_q == S_IDLE) ? AM_NONE : dec_mode;
   assign bus.illegal     = (state_q == S_DECODE) && !dec_legal;
   assign bus.z_flag      = z_q;
   assign bus.n_flag      = n_q;

endmodule

// File: tb/tb_alu_ctrl.sv
// Directed self-checking bench for alu_ctrl with a write-back scoreboard.
module tb_alu_ctrl;

   logic clk;
   logic rst;

   alu_ctrl_if bus ();

   alu_ctrl dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      logic [1:0] wa;
      logic [2:0] mode;
      logic       z;
      logic       n;
   } exp_t;

   exp_t sb [$];
   int   n_assert = 0;
   int   n_fail   = 0;
   int   we_cnt   = 0;
   int   we_base  = 0;
   int   idx      = 0;
   int   last     = 0;
   logic acc;
   logic [7:0] prog [3];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [2:0] mode_of(input logic [3:0] op);
      case (op)
         4'd4:    return 3'b001;
         4'd5:    return 3'b010;
         4'd8:    return 3'b011;
         4'd9:    return 3'b100;
         4'd10:   return 3'b101;
         default: return 3'b000;
      endcase
   endfunction

   function automatic void push(input logic [7:0] ins, input logic z, input logic n);
      exp_t e;
      e.wa   = ins[3:2];
      e.mode = mode_of(ins[7:4]);
      e.z    = z;
      e.n    = n;
      sb.push_back(e);
   endfunction

   // Presents one instruction for a single cycle; called at a negedge with instr_ready high.
   task automatic issue(input logic [7:0] ins);
      bus.instr       = ins;
      bus.instr_valid = 1'b1;
      @(negedge clk);
      bus.instr_valid = 1'b0;
   endtask

   // Write-back monitor: every rf_we pulse must match the oldest expected write.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (bus.rf_we === 1'b1) begin
            we_cnt++;
            chk("sb_nonempty_at_we", 8'(sb.size() != 0), 8'd1);
            if (sb.size() != 0) begin
               e = sb.pop_front();
               chk("wb_wa",   8'(bus.rf_wa),    8'(e.wa));
               chk("wb_mode", 8'(bus.alu_mode), 8'(e.mode));
               chk("wb_z",    8'(bus.z_flag),   8'(e.z));
               chk("wb_n",    8'(bus.n_flag),   8'(e.n));
            end
         end
         if (bus.rf_we === 1'b1 || bus.illegal === 1'b1)
            chk("excl_we_ill_rdy",
                8'($countones({bus.rf_we, bus.illegal, bus.instr_ready})), 8'd1);
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      prog[0] = 8'h46;
      prog[1] = 8'h8D;
      prog[2] = 8'h94;
      bus.instr       = 8'h00;
      bus.instr_valid = 1'b0;
      bus.alu_z       = 1'b0;
      bus.alu_n       = 1'b0;
      rst             = 1'b1;
      repeat (3) @(negedge clk);

      // Reset values
      chk("rst_ready", 8'(bus.instr_ready), 8'd1);
      chk("rst_we",    8'(bus.rf_we),       8'd0);
      chk("rst_ill",   8'(bus.illegal),     8'd0);
      chk("rst_z",     8'(bus.z_flag),      8'd0);
      chk("rst_n",     8'(bus.n_flag),      8'd0);
      chk("rst_mode",  8'(bus.alu_mode),    8'd0);
      chk("rst_ra",    8'(bus.rf_ra),       8'd0);
      chk("rst_rb",    8'(bus.rf_rb),       8'd0);
      chk("rst_wa",    8'(bus.rf_wa),       8'd0);

      // Reset has priority over a handshake
      bus.instr       = 8'h46;
      bus.instr_valid = 1'b1;
      @(negedge clk);
      chk("rst_prio_ready", 8'(bus.instr_ready), 8'd1);
      chk("rst_prio_ra",    8'(bus.rf_ra),       8'd0);
      bus.instr_valid = 1'b0;
      rst             = 1'b0;
      @(negedge clk);
      chk("post_rst_ready", 8'(bus.instr_ready), 8'd1);

      // ADD r1,r2
      bus.alu_z = 1'b0;
      bus.alu_n = 1'b1;
      push(8'h46, 1'b0, 1'b1);
      issue(8'h46);
      chk("add_dec_ready", 8'(bus.instr_ready), 8'd0);
      chk("add_dec_ra",    8'(bus.rf_ra),       8'd1);
      chk("add_dec_rb",    8'(bus.rf_rb),       8'd2);
      chk("add_dec_mode",  8'(bus.alu_mode),    8'h1);
      chk("add_dec_we",    8'(bus.rf_we),       8'd0);
      @(negedge clk);
      chk("add_exec_mode", 8'(bus.alu_mode),    8'h1);
      chk("add_exec_we",   8'(bus.rf_we),       8'd0);
      @(negedge clk);
      chk("add_wb_we",     8'(bus.rf_we),       8'd1);
      chk("add_wb_wa",     8'(bus.rf_wa),       8'd1);
      @(negedge clk);
      chk("add_idle_ready", 8'(bus.instr_ready), 8'd1);
      chk("add_idle_we",    8'(bus.rf_we),       8'd0);
      chk("add_idle_mode",  8'(bus.alu_mode),    8'd0);

      // SUB r2,r1 with zero result
      bus.alu_z = 1'b1;
      bus.alu_n = 1'b0;
      push(8'h59, 1'b1, 1'b0);
      issue(8'h59);
      chk("sub_dec_mode", 8'(bus.alu_mode), 8'h2);
      repeat (2) @(negedge clk);
      chk("sub_wb_z", 8'(bus.z_flag), 8'd1);
      chk("sub_wb_n", 8'(bus.n_flag), 8'd0);
      @(negedge clk);

      // NOP: two-cycle turnaround, flags untouched
      bus.alu_z = 1'b0;
      bus.alu_n = 1'b1;
      issue(8'h00);
      chk("nop_dec_ready", 8'(bus.instr_ready), 8'd0);
      chk("nop_dec_mode",  8'(bus.alu_mode),    8'd0);
      chk("nop_dec_ill",   8'(bus.illegal),     8'd0);
      @(negedge clk);
      chk("nop_ready2", 8'(bus.instr_ready), 8'd1);
      chk("nop_z",      8'(bus.z_flag),      8'd1);
      chk("nop_n",      8'(bus.n_flag),      8'd0);

      // Illegal opcode: one-cycle pulse, no write
      issue(8'hF0);
      chk("ill_pulse", 8'(bus.illegal),     8'd1);
      chk("ill_mode",  8'(bus.alu_mode),    8'd0);
      chk("ill_ready", 8'(bus.instr_ready), 8'd0);
      @(negedge clk);
      chk("ill_clear",  8'(bus.illegal),     8'd0);
      chk("ill_ready2", 8'(bus.instr_ready), 8'd1);
      chk("ill_z",      8'(bus.z_flag),      8'd1);
      chk("ill_n",      8'(bus.n_flag),      8'd0);

      // Back-to-back with instr_valid held high
      bus.alu_z       = 1'b1;
      bus.alu_n       = 1'b1;
      we_base         = we_cnt;
      idx             = 0;
      last            = 0;
      bus.instr       = prog[0];
      bus.instr_valid = 1'b1;
      for (int c = 0; c < 40 && idx < 3; c++) begin
         acc = bus.instr_ready;
         if (acc) begin
            if (idx > 0) chk("b2b_spacing", 8'(c - last), 8'd4);
            last = c;
            push(prog[idx], 1'b1, 1'b1);
            idx++;
         end
         @(negedge clk);
         if (acc) begin
            if (idx < 3) bus.instr = prog[idx];
            else         bus.instr_valid = 1'b0;
         end
      end
      bus.instr_valid = 1'b0;
      chk("b2b_accepts", 8'(idx), 8'd3);
      repeat (6) @(negedge clk);
      chk("b2b_we_count", 8'(we_cnt - we_base), 8'd3);

      // Reset during EXEC aborts the write and clears flags
      issue(8'h46);
      @(negedge clk);
      chk("abort_exec_ready", 8'(bus.instr_ready), 8'd0);
      chk("abort_exec_mode",  8'(bus.alu_mode),    8'h1);
      rst = 1'b1;
      @(negedge clk);
      chk("abort_we", 8'(bus.rf_we),  8'd0);
      chk("abort_z",  8'(bus.z_flag), 8'd0);
      chk("abort_n",  8'(bus.n_flag), 8'd0);
      rst = 1'b0;
      @(negedge clk);
      chk("abort_ready", 8'(bus.instr_ready), 8'd1);
      chk("abort_we2",   8'(bus.rf_we),       8'd0);
      chk("abort_z2",    8'(bus.z_flag),      8'd0);
      chk("abort_n2",    8'(bus.n_flag),      8'd0);
      repeat (4) @(negedge clk);
      chk("sb_empty", 8'(sb.size()), 8'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/alu_ctrl.md
ALU_CTRL -- requirements
Module: alu_ctrl

Interface
REQ-001 Parameter: OPW, 4, opcode field width (instr[7:4]); fixed, not overridable per instance.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset; synchronous, active-high.
REQ-004 instr  input  8  instruction: [7:4] opcode, [3:2] ra (dest and source A), [1:0] rb (source B).
REQ-005 instr_valid  input  1  instr is presented this cycle.
REQ-006 instr_ready  output  1  controller accepts instr this cycle.
REQ-007 rf_ra, rf_rb  output  2 each  register-file read addresses.
REQ-008 rf_wa  output  2  register-file write address.
REQ-009 rf_we  output  1  register-file write strobe, one-cycle pulse.
REQ-010 alu_mode  output  3  ALU operation select.
REQ-011 alu_z, alu_n  input  1 each  ALU zero/negative result indications.
REQ-012 z_flag, n_flag  output  1 each  registered condition flags.
REQ-013 illegal  output  1  one-cycle pulse on undefined opcode.

Function
REQ-014 FSM states SHALL be IDLE, DECODE, EXEC, WB.
REQ-015 instr_ready SHALL be 1 only in IDLE; handshake occurs when instr_valid && instr_ready; instr is latched into an internal IR on that edge.
REQ-016 IDLE -> DECODE on handshake; otherwise stay in IDLE.
REQ-017 In DECODE: rf_ra = IR[3:2], rf_rb = IR[1:0], alu_mode driven from opcode; held stable through EXEC.
REQ-018 Opcode map: 0 NOP; 4 ADD (001); 5 SUB (010); 8 NAND (011); 9 SHL (100); 10 SHR (101); all others illegal. alu_mode = 000 in IDLE, for NOP and illegal opcodes.
REQ-019 NOP and illegal: DECODE -> IDLE; no write; flags unchanged; illegal pulses 1 during DECODE for illegal opcodes only.
REQ-020 Legal ALU op: DECODE -> EXEC -> WB -> IDLE; at the end of EXEC, z_flag <= alu_z and n_flag <= alu_n.
REQ-021 In WB: rf_we = 1 and rf_wa = IR[3:2] for exactly one cycle.
REQ-022 Latency: handshake edge to rf_we high = 3 cycles; next instr_ready = 4 cycles after handshake; NOP/illegal = 2 cycles.
REQ-023 instr_valid while not ready SHALL be ignored: no latch, no state change. Upstream holds instr until accepted.
REQ-024 Back-to-back: a new handshake is legal in the first IDLE cycle after WB.
REQ-025 rf_we, illegal and instr_ready SHALL never be high together.

Reset
REQ-026 rst high at any edge: state = IDLE, IR = 0, z_flag = 0, n_flag = 0, rf_we = 0, illegal = 0, alu_mode = 000, rf_ra/rf_rb/rf_wa = 0; rst takes priority over handshake.
REQ-027 rst during EXEC or WB SHALL abort the operation: no rf_we pulse and no flag update after the reset edge.
REQ-028 instr_ready = 1 in the first cycle after rst deasserts.

Structure
REQ-029 Shared package (alu_pkg): opcode constants, alu_mode codes, FSM state encoding; the ALU and alu_ctrl both use it.
REQ-030 One combinational sub-module, alu_decode (opcode -> alu_mode, legal, writes_rf); the FSM and registers stay in alu_ctrl.

Verification
REQ-031 Reset, then instr=0x46 (ADD r1,r2) valid -> rf_ra=1, rf_rb=2, alu_mode=001 from DECODE; rf_we=1, rf_wa=1 exactly 3 cycles after handshake.
REQ-032 SUB with alu_z=1, alu_n=0 in EXEC -> z_flag=1, n_flag=0 from the WB cycle onward; a following NOP leaves flags unchanged.
REQ-033 instr=0x00 (NOP) -> no rf_we, instr_ready again 2 cycles after handshake; instr=0xF0 -> illegal pulse 1 cycle, no rf_we.
REQ-034 instr_valid held high continuously with 0x46, 0x8D, 0x94 -> exactly one accept per 4 cycles, three rf_we pulses with rf_wa=1,3,1, alu_mode=001,011,100.
REQ-035 rst asserted in EXEC of an ADD -> no rf_we, flags 0, instr_ready=1 in the first cycle after rst deasserts.
